// File: rtl/tff_bank_pkg.sv
// tff_bank_pkg: mode encoding and default sizes for the tff_bank flip-flop bank
package tff_bank_pkg;
  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_LOAD   = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_COUNT  = 2'b11
  } mode_e;
  localparam int TFF_BANK_WIDTH = 8;
  localparam int TFF_BANK_CNT_W = 16;
endpackage

// File: rtl/tff_bank_checker.sv
// tff_bank_checker: passive property checker for tff_bank, bound in under TFF_BANK_ASSERT_EN
module tff_bank_checker
  import tff_bank_pkg::*;
#(
  parameter int WIDTH = TFF_BANK_WIDTH,
  parameter int CNT_W = TFF_BANK_CNT_W
) (
  input logic             clk,
  input logic             rst,
  input logic             en,
  input logic [1:0]       mode,
  input logic [WIDTH-1:0] d,
  input logic [WIDTH-1:0] t,
  input logic             cnt_clr,
  input logic [WIDTH-1:0] q,
  input logic             wrap,
  input logic [CNT_W-1:0] tog_cnt
);
  property p_reset_zero;
    @(posedge clk) disable iff (rst) $fell(rst) |-> q == '0;
  endproperty
  property p_load;
    @(posedge clk) disable iff (rst) (en && mode == MODE_LOAD) |=> q == $past(d);
  endproperty
  property p_toggle;
    @(posedge clk) disable iff (rst) (en && mode == MODE_TOGGLE) |=> q == $past(q ^ t);
  endproperty
  property p_count;
    @(posedge clk) disable iff (rst) (en && mode == MODE_COUNT) |=> q == $past(q + 1'b1);
  endproperty
  property p_hold;
    @(posedge clk) disable iff (rst) (!en || mode == MODE_HOLD) |=> $stable(q);
  endproperty
  property p_wrap_zero;
    @(posedge clk) disable iff (rst) wrap |-> q == '0;
  endproperty
  property p_no_decrement;
    @(posedge clk) disable iff (rst) !cnt_clr |=> tog_cnt >= $past(tog_cnt);
  endproperty
  property p_saturate;
    @(posedge clk) disable iff (rst) (&tog_cnt && !cnt_clr) |=> &tog_cnt;
  endproperty
  a_reset_zero:   assert property (p_reset_zero);
  a_load:         assert property (p_load);
  a_toggle:       assert property (p_toggle);
  a_count:        assert property (p_count);
  a_hold:         assert property (p_hold);
  a_wrap_zero:    assert property (p_wrap_zero);
  a_no_decrement: assert property (p_no_decrement);
  a_saturate:     assert property (p_saturate);
endmodule

// File: rtl/tff_bank.sv
// tff_bank: WIDTH-bit hold/load/toggle/count register with wrap pulse and saturating change counter; checker under TFF_BANK_ASSERT_EN
module tff_bank
  import tff_bank_pkg::*;
#(
  parameter int WIDTH = TFF_BANK_WIDTH,
  parameter int CNT_W = TFF_BANK_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] t,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic [CNT_W-1:0] tog_cnt
);
  mode_e            m;
  logic [WIDTH-1:0] q_nxt;
  assign m = mode_e'(mode);
  always_comb q_nxt = !en ? q :
                      m == MODE_LOAD   ? d :
                      m == MODE_TOGGLE ? q ^ t :
                      m == MODE_COUNT  ? q + 1'b1 : q;
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      wrap    <= 1'b0;
      tog_cnt <= '0;
    end else begin
      q       <= q_nxt;
      wrap    <= en && m == MODE_COUNT && &q;
      tog_cnt <= cnt_clr ? '0 : (q_nxt != q && !(&tog_cnt)) ? tog_cnt + 1'b1 : tog_cnt;
    end
  end
`ifdef TFF_BANK_ASSERT_EN
  tff_bank_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_chk (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .t(t),
    .cnt_clr(cnt_clr), .q(q), .wrap(wrap), .tog_cnt(tog_cnt)
  );
`endif
endmodule

// File: tb/tb_tff_bank.sv
// tb_tff_bank: directed plan scenarios plus random traffic against an integer reference model
module tb_tff_bank;
  logic        clk = 0;
  logic        rst = 1;
  logic        en = 1;
  logic [1:0]  mode = 2'b01;
  logic [7:0]  d = 8'hA5;
  logic [7:0]  t = 8'h00;
  logic        cnt_clr = 0;
  logic [7:0]  q, q2;
  logic        wrap, wrap2;
  logic [15:0] tog_cnt;
  logic [1:0]  tog_cnt2;
  int n_chk = 0;
  int n_fail = 0;
  int m_q = 0;
  int m_c16 = 0;
  int m_c2 = 0;
  int m_wrap = 0;

  always #5 clk = ~clk;

  tff_bank #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .t(t),
    .cnt_clr(cnt_clr), .q(q), .wrap(wrap), .tog_cnt(tog_cnt)
  );
  tff_bank #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .t(t),
    .cnt_clr(cnt_clr), .q(q2), .wrap(wrap2), .tog_cnt(tog_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int c, input int max);
    return (c + 1 > max) ? max : c + 1;
  endfunction

  task automatic cyc();
    int nq;
    @(posedge clk);
    if (rst) begin
      m_q = 0; m_c16 = 0; m_c2 = 0; m_wrap = 0;
    end else begin
      case (mode)
        2'b01:   nq = d;
        2'b10:   nq = m_q ^ int'(t);
        2'b11:   nq = (m_q + 1) % 256;
        default: nq = m_q;
      endcase
      if (!en) nq = m_q;
      m_wrap = (en && mode == 2'b11 && m_q == 255) ? 1 : 0;
      m_c16 = cnt_clr ? 0 : (nq != m_q) ? sat_inc(m_c16, 65535) : m_c16;
      m_c2  = cnt_clr ? 0 : (nq != m_q) ? sat_inc(m_c2, 3) : m_c2;
      m_q = nq;
    end
    #1;
    chk("q", 32'(q), 32'(m_q));
    chk("q_cnt2", 32'(q2), 32'(m_q));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    chk("wrap_cnt2", 32'(wrap2), 32'(m_wrap));
    chk("tog_cnt", 32'(tog_cnt), 32'(m_c16));
    chk("tog_cnt_cnt2", 32'(tog_cnt2), 32'(m_c2));
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] md,
                       input logic [7:0] dv, input logic [7:0] tv, input logic c);
    rst = r; en = e; mode = md; d = dv; t = tv; cnt_clr = c;
    cyc();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'b01, 8'hA5, 8'h00, 0);
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_tog", 32'(tog_cnt), 32'h0);
    end
    drive(0, 1, 2'b01, 8'hA5, 8'h00, 0);
    chk("first_load_q", 32'(q), 32'hA5);
    chk("first_load_tog", 32'(tog_cnt), 32'h1);
    drive(0, 1, 2'b01, 8'h0F, 8'h00, 0);
    drive(0, 1, 2'b10, 8'h00, 8'hFF, 0);
    chk("tgl_ff", 32'(q), 32'hF0);
    drive(0, 1, 2'b10, 8'h00, 8'h00, 0);
    chk("tgl_00", 32'(q), 32'hF0);
    drive(0, 1, 2'b10, 8'h00, 8'h81, 0);
    chk("tgl_81", 32'(q), 32'h71);
    chk("tgl_tog", 32'(tog_cnt), 32'h4);
    drive(0, 1, 2'b01, 8'hFE, 8'h00, 0);
    drive(0, 1, 2'b11, 8'h00, 8'h5A, 0);
    chk("cnt_ff", 32'(q), 32'hFF);
    chk("cnt_ff_wrap", 32'(wrap), 32'h0);
    drive(0, 1, 2'b11, 8'h00, 8'h5A, 0);
    chk("cnt_00", 32'(q), 32'h00);
    chk("cnt_00_wrap", 32'(wrap), 32'h1);
    drive(0, 1, 2'b11, 8'h00, 8'h5A, 0);
    chk("cnt_01", 32'(q), 32'h01);
    chk("cnt_01_wrap", 32'(wrap), 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 2'b11, 8'h00, 8'h00, 0);
      chk("en0_q", 32'(q), 32'h01);
      chk("en0_tog", 32'(tog_cnt), 32'h8);
    end
    drive(0, 1, 2'b11, 8'h00, 8'h00, 0);
    chk("en1_q", 32'(q), 32'h02);
    drive(0, 1, 2'b00, 8'h00, 8'h00, 1);
    for (int i = 0; i < 5; i++) drive(0, 1, 2'b10, 8'h00, 8'hFF, 0);
    chk("sat_tog2", 32'(tog_cnt2), 32'h3);
    chk("sat_tog16", 32'(tog_cnt), 32'h5);
    drive(0, 1, 2'b10, 8'h00, 8'hFF, 1);
    chk("clr_tog2", 32'(tog_cnt2), 32'h0);
    chk("clr_q", 32'(q2), 32'h02);
    drive(0, 1, 2'b10, 8'h00, 8'hFF, 0);
    chk("post_clr_tog2", 32'(tog_cnt2), 32'h1);
    drive(0, 1, 2'b01, 8'h36, 8'h00, 0);
    drive(0, 1, 2'b11, 8'h00, 8'h00, 0);
    chk("mid_37", 32'(q), 32'h37);
    drive(1, 1, 2'b11, 8'h00, 8'h00, 0);
    chk("mid_rst_q", 32'(q), 32'h0);
    chk("mid_rst_tog", 32'(tog_cnt), 32'h0);
    drive(0, 1, 2'b11, 8'h00, 8'h00, 0);
    chk("mid_resume", 32'(q), 32'h01);
    for (int i = 0; i < 400; i++) begin
      logic [7:0] dv, tv;
      dv = ($urandom_range(0, 3) == 0) ? q : 8'($urandom);
      tv = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 5) != 0,
            2'($urandom), dv, tv, $urandom_range(0, 19) == 0);
    end
    drive(0, 1, 2'b01, 8'hFF, 8'h00, 0);
    drive(0, 1, 2'b11, 8'h00, 8'h00, 0);
    chk("rand_tail_wrap", 32'(wrap), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
